dmem_access_unit: RTL and testbench

- Memory-stage responder for the mem_read/mem_write/store_funct3 fields of the pipeline control word.
- Takes one load/store per instruction from the EX/MEM register and drives the data-memory bus (read/write/address/wdata/byte_enable, resp handshake). It also produces the byte-aligned, sign- or zero-extended load result.
- Stalls the whole pipeline while a transaction is outstanding.
- Sits between the EX/MEM pipeline register and the data cache/arbiter.

---
 rtl/dmem_access_unit_pkg.sv | 56 +++++
 rtl/dmem_access_unit_load_align.sv | 29 ++
 rtl/dmem_access_unit.sv | 151 +++++++++++++++
 tb/tb_dmem_access_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_access_unit_pkg.sv
// Shared types for the memory-stage data access path.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package dmem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef logic [3:0] rv32i_mem_wmask;

    // A request is legal only if it is exactly one of load/store, uses a
    // known funct3 and is naturally aligned for its access size.
    function automatic logic access_legal(input logic       rd,
                                          input logic       wr,
                                          input logic [2:0] f3,
                                          input logic [1:0] off);
        logic ok;
        ok = 1'b0;
        if (rd ^ wr) begin
            if (rd) begin
                case (f3)
                    lb, lbu: ok = 1'b1;
                    lh, lhu: ok = ~off[0];
                    lw:      ok = (off == 2'b00);
                    default: ok = 1'b0;
                endcase
            end else begin
                case (f3)
                    sb:      ok = 1'b1;
                    sh:      ok = ~off[0];
                    sw:      ok = (off == 2'b00);
                    default: ok = 1'b0;
                endcase
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/dmem_access_unit_load_align.sv
// Load alignment: shifts the addressed lane down and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none.
module dmem_access_unit_load_align
    import dmem_access_unit_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [31:0] w_shifted;

    assign w_shifted = i_rdata >> {i_offset, 3'b000};

    // Select the extension for the access size named by funct3.
    always_comb begin
        o_data = w_shifted;
        case (i_funct3)
            lb:      o_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            lh:      o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            lbu:     o_data = {24'h0, w_shifted[7:0]};
            lhu:     o_data = {16'h0, w_shifted[15:0]};
            default: o_data = w_shifted;
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage load/store responder driving the data-memory bus.
// Latency: accept cycle 0, bus strobe from cycle 1 until resp, result in the cycle after resp.
// Backpressure: stall held from legal accept through the resp cycle; illegal requests only pulse req_err.
module dmem_access_unit
    import dmem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              stall,
    output logic [31:0]       load_data,
    output logic              load_valid,
    output logic              req_err,
    output logic              dmem_read,
    output logic              dmem_write,
    output logic [ADDR_W-1:0] dmem_address,
    output logic [31:0]       dmem_wdata,
    output rv32i_mem_wmask    dmem_byte_enable,
    input  logic [31:0]       dmem_rdata,
    input  logic              dmem_resp
);

    dmem_state_t    r_state;
    dmem_state_t    w_next_state;
    logic           w_stall;
    logic           w_req;
    logic           w_legal;
    logic           w_accept;
    logic           w_illegal;
    logic [31:0]    w_aligned;
    rv32i_mem_wmask w_store_be;

    logic           r_dmem_read;
    logic           r_dmem_write;
    logic [ADDR_W-1:0] r_dmem_address;
    logic [31:0]    r_dmem_wdata;
    rv32i_mem_wmask r_dmem_byte_enable;
    logic [31:0]    r_load_data;
    logic           r_load_valid;
    logic           r_req_err;
    logic [2:0]     r_funct3;
    logic [1:0]     r_offset;

    assign w_req     = req_valid & (req_read | req_write);
    assign w_legal   = access_legal(req_read, req_write, req_funct3, req_addr[1:0]);
    assign w_accept  = (r_state == IDLE) & w_req & w_legal;
    assign w_illegal = (r_state == IDLE) & w_req & ~w_legal;

    // Store lane mask; the size is already known legal when this is used.
    always_comb begin
        w_store_be = 4'b0000;
        case (req_funct3)
            sb:      w_store_be = 4'b0001 << req_addr[1:0];
            sh:      w_store_be = 4'b0011 << req_addr[1:0];
            sw:      w_store_be = 4'b1111;
            default: w_store_be = 4'b0000;
        endcase
    end

    dmem_access_unit_load_align u_load_align (
        .i_rdata  (dmem_rdata),
        .i_offset (r_offset),
        .i_funct3 (r_funct3),
        .o_data   (w_aligned)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // Next-state and combinational stall; DONE releases the pipeline and never accepts.
    always_comb begin
        w_next_state = r_state;
        w_stall      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = BUSY;
                    w_stall      = 1'b1;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (dmem_resp) w_next_state = DONE;
            end
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Registered bus outputs, latched request context and result pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dmem_read        <= 1'b0;
            r_dmem_write       <= 1'b0;
            r_dmem_address     <= '0;
            r_dmem_wdata       <= '0;
            r_dmem_byte_enable <= '0;
            r_load_data        <= '0;
            r_load_valid       <= 1'b0;
            r_req_err          <= 1'b0;
            r_funct3           <= '0;
            r_offset           <= '0;
        end else begin
            r_req_err    <= w_illegal;
            r_load_valid <= 1'b0;
            if (w_accept) begin
                r_dmem_read    <= req_read;
                r_dmem_write   <= req_write;
                r_dmem_address <= {req_addr[ADDR_W-1:2], 2'b00};
                r_funct3       <= req_funct3;
                r_offset       <= req_addr[1:0];
                if (req_write) begin
                    r_dmem_wdata       <= req_wdata << {req_addr[1:0], 3'b000};
                    r_dmem_byte_enable <= w_store_be;
                end else begin
                    r_dmem_wdata       <= '0;
                    r_dmem_byte_enable <= '0;
                end
            end
            if ((r_state == BUSY) && dmem_resp) begin
                r_dmem_read  <= 1'b0;
                r_dmem_write <= 1'b0;
                if (r_dmem_read) begin
                    r_load_data  <= w_aligned;
                    r_load_valid <= 1'b1;
                end
            end
        end
    end

    assign stall            = w_stall;
    assign load_data        = r_load_data;
    assign load_valid       = r_load_valid;
    assign req_err          = r_req_err;
    assign dmem_read        = r_dmem_read;
    assign dmem_write       = r_dmem_write;
    assign dmem_address     = r_dmem_address;
    assign dmem_wdata       = r_dmem_wdata;
    assign dmem_byte_enable = r_dmem_byte_enable;

endmodule

// File: tb/tb_dmem_access_unit.sv
// Bench for dmem_access_unit: directed loads/stores, illegal accesses, zero-wait and reset-abort.
// Expected bus transactions, load results and error pulses are queued at issue time.
// A negedge monitor pops and compares whenever the DUT presents one of them.
module tb_dmem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_read, req_write;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic        stall;
    logic [31:0] load_data;
    logic        load_valid, req_err, dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_byte_enable;
    logic        dmem_resp;

    always #5 clk = ~clk;

    dmem_access_unit #(.ADDR_W(32)) dut (
        .clk              (clk),
        .rst              (rst),
        .req_valid        (req_valid),
        .req_read         (req_read),
        .req_write        (req_write),
        .req_funct3       (req_funct3),
        .req_addr         (req_addr),
        .req_wdata        (req_wdata),
        .stall            (stall),
        .load_data        (load_data),
        .load_valid       (load_valid),
        .req_err          (req_err),
        .dmem_read        (dmem_read),
        .dmem_write       (dmem_write),
        .dmem_address     (dmem_address),
        .dmem_wdata       (dmem_wdata),
        .dmem_byte_enable (dmem_byte_enable),
        .dmem_rdata       (dmem_rdata),
        .dmem_resp        (dmem_resp)
    );

    localparam int EV_NONE = -1;
    localparam int EV_BUS  = 0;
    localparam int EV_LOAD = 1;
    localparam int EV_ERR  = 2;

    typedef struct {
        int          kind;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] data;
    } ev_t;

    ev_t exp_q[$];
    int  n_checks = 0;
    int  n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    function automatic ev_t pop_ev();
        ev_t e;
        e.kind = EV_NONE; e.rd = 1'b0; e.wr = 1'b0;
        e.addr = '0; e.wdata = '0; e.be = '0; e.data = '0;
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return e;
    endfunction

    // Monitor: compare each presented bus transaction / load result / error pulse.
    logic prev_strobe = 1'b0;
    always @(negedge clk) begin
        ev_t e;
        if ((dmem_read | dmem_write) && !prev_strobe) begin
            e = pop_ev();
            chk("bus_event_kind", e.kind, EV_BUS);
            chk("bus_strobes", {30'h0, dmem_read, dmem_write}, {30'h0, e.rd, e.wr});
            chk("bus_address", dmem_address, e.addr);
            chk("bus_byte_enable", {28'h0, dmem_byte_enable}, {28'h0, e.be});
            if (e.wr) chk("bus_wdata", dmem_wdata, e.wdata);
        end
        prev_strobe = dmem_read | dmem_write;
        if (load_valid) begin
            e = pop_ev();
            chk("load_event_kind", e.kind, EV_LOAD);
            chk("load_data", load_data, e.data);
        end
        if (req_err) begin
            e = pop_ev();
            chk("err_event_kind", e.kind, EV_ERR);
        end
    end

    // Issue one request from IDLE; caller and task both sit #1 after a posedge.
    task automatic run_req(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input logic [31:0] rdata, input int waits,
                           input bit legal, input bit drop,
                           input logic [3:0] exp_be, input logic [31:0] exp_wd,
                           input logic [31:0] exp_ld);
        ev_t e;
        e.rd = rd; e.wr = wr; e.addr = {addr[31:2], 2'b00};
        e.wdata = exp_wd; e.be = exp_be; e.data = exp_ld;
        if (legal) begin
            e.kind = EV_BUS;  exp_q.push_back(e);
            if (rd) begin e.kind = EV_LOAD; exp_q.push_back(e); end
        end else begin
            e.kind = EV_ERR;  exp_q.push_back(e);
        end
        req_valid = 1'b1; req_read = rd; req_write = wr;
        req_funct3 = f3; req_addr = addr; req_wdata = wd;
        #1;
        chk("stall_on_accept", {31'h0, stall}, {31'h0, legal});
        @(posedge clk); #1;
        if (!legal) begin
            req_valid = 1'b0;
            chk("stall_after_err", {31'h0, stall}, 32'h0);
            chk("no_strobe_on_err", {31'h0, dmem_read | dmem_write}, 32'h0);
            return;
        end
        if (drop) req_valid = 1'b0;
        for (int i = 0; i <= waits; i++) begin
            if (i == waits) begin dmem_resp = 1'b1; dmem_rdata = rdata; end
            #1;
            chk("stall_busy", {31'h0, stall}, 32'h1);
            chk("strobe_held", {30'h0, dmem_read, dmem_write}, {30'h0, rd, wr});
            chk("addr_held", dmem_address, {addr[31:2], 2'b00});
            @(posedge clk); #1;
        end
        dmem_resp = 1'b0; dmem_rdata = 32'h0BAD0BAD;
        #1;
        chk("stall_done", {31'h0, stall}, 32'h0);
        chk("strobe_off_done", {31'h0, dmem_read | dmem_write}, 32'h0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("no_issue_from_done", {31'h0, dmem_read | dmem_write}, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0;
        req_funct3 = 3'b0; req_addr = '0; req_wdata = '0;
        dmem_rdata = '0; dmem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", {31'h0, stall}, 32'h0);
        chk("rst_strobes", {30'h0, dmem_read, dmem_write}, 32'h0);
        chk("rst_pulses", {30'h0, load_valid, req_err}, 32'h0);
        chk("rst_address", dmem_address, 32'h0);
        chk("rst_wdata", dmem_wdata, 32'h0);
        chk("rst_byte_enable", {28'h0, dmem_byte_enable}, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        //       rd    wr    f3      addr          wdata         rdata         w  lg dr be       exp_wd        exp_ld
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_1000, 32'h0,        32'hDEADBEEF, 3, 1, 0, 4'b0000, 32'h0,        32'hDEADBEEF);
        run_req(1'b1, 1'b0, 3'b000, 32'h0000_2003, 32'h0,        32'h80FF1234, 1, 1, 0, 4'b0000, 32'h0,        32'hFFFFFF80);
        run_req(1'b1, 1'b0, 3'b100, 32'h0000_2003, 32'h0,        32'h80FF1234, 0, 1, 0, 4'b0000, 32'h0,        32'h00000080);
        run_req(1'b1, 1'b0, 3'b001, 32'h0000_2002, 32'h0,        32'h80FF1234, 2, 1, 0, 4'b0000, 32'h0,        32'hFFFF80FF);
        run_req(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0,        32'h80FF1234, 0, 1, 0, 4'b0000, 32'h0,        32'h000080FF);
        run_req(1'b0, 1'b1, 3'b000, 32'h0000_3001, 32'h000000AB, 32'h0,        1, 1, 0, 4'b0010, 32'h0000AB00, 32'h0);
        run_req(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h00001234, 32'h0,        0, 1, 0, 4'b1100, 32'h12340000, 32'h0);
        run_req(1'b0, 1'b1, 3'b010, 32'h0000_3004, 32'hCAFEF00D, 32'h0,        2, 1, 0, 4'b1111, 32'hCAFEF00D, 32'h0);
        // Illegal: misaligned lw, misaligned sh, read+write, unknown load funct3.
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_1002, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0);
        run_req(1'b0, 1'b1, 3'b001, 32'h0000_1001, 32'h00001234, 32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0);
        run_req(1'b1, 1'b1, 3'b010, 32'h0000_1000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0);
        run_req(1'b1, 1'b0, 3'b011, 32'h0000_1000, 32'h0,        32'h0,        0, 0, 0, 4'b0000, 32'h0,        32'h0);
        // Zero-wait memory then back-to-back lw.
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0,        32'h11223344, 0, 1, 0, 4'b0000, 32'h0,        32'h11223344);
        run_req(1'b1, 1'b0, 3'b010, 32'h0000_5004, 32'h0,        32'h55667788, 0, 1, 0, 4'b0000, 32'h0,        32'h55667788);
        // req_valid dropped while BUSY: transaction still completes.
        run_req(1'b1, 1'b0, 3'b001, 32'h0000_6000, 32'h0,        32'h0000FFFE, 2, 1, 1, 4'b0000, 32'h0,        32'hFFFFFFFE);

        // Reset in the second BUSY cycle; late resp must be ignored.
        begin
            ev_t e;
            e.kind = EV_BUS; e.rd = 1'b1; e.wr = 1'b0; e.addr = 32'h0000_4000;
            e.wdata = '0; e.be = 4'b0000; e.data = '0;
            exp_q.push_back(e);
        end
        req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0;
        req_funct3 = 3'b010; req_addr = 32'h0000_4000;
        @(posedge clk); #1;
        chk("abort_busy1_read", {31'h0, dmem_read}, 32'h1);
        @(posedge clk); #1;
        chk("abort_busy2_stall", {31'h0, stall}, 32'h1);
        rst = 1'b1; req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; dmem_resp = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("abort_strobes_off", {30'h0, dmem_read, dmem_write}, 32'h0);
        chk("abort_stall_off", {31'h0, stall}, 32'h0);
        @(posedge clk); #1;
        dmem_resp = 1'b0;
        chk("abort_no_load_valid", {31'h0, load_valid}, 32'h0);
        chk("abort_resp_ignored", {30'h0, dmem_read, stall}, 32'h0);
        chk("abort_load_data_reset", load_data, 32'h0);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
